img_filter_downscaler: RTL and testbench

- Parametrised next-generation image engine: loads a PIX_W-bit IMG_W x IMG_H frame, applies a 3x3 binomial smoothing kernel, and writes the result to an output buffer.
- The output is either the full-resolution filtered frame or a 2:1 decimated frame, selected by ds_en.
- Host interface is the status/addr/data/out/end_process protocol used by the existing downsampling machine, plus reset and mode select.
- Sits between the frame loader and the result dump path in the image-downsampling datapath.

---
 rtl/img_pkg.sv | 32 +++
 rtl/img_filter_downscaler_ram.sv | 36 +++
 rtl/img_filter_downscaler.sv | 209 ++++++++++++++++++++
 tb/tb_img_filter_downscaler.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared encodings and constants for the 3x3 binomial filter / 2:1 downscaler.
package img_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b10;
  localparam logic [1:0] ST_PROC = 2'b01;
  localparam logic [1:0] ST_READ = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLast,
    StWrite,
    StDone
  } fsm_state_e;

  // Binomial weights indexed by tap k = 3*row + col.
  localparam logic [8:0][2:0] KERNEL_W = {3'd1, 3'd2, 3'd1,
                                          3'd2, 3'd4, 3'd2,
                                          3'd1, 3'd2, 3'd1};

  localparam int unsigned ROUND = 8;
  localparam int unsigned SHIFT = 4;

  // Edge replication: pull an out-of-frame tap coordinate back onto the border.
  function automatic int clamp_coord(input int c, input int hi);
    if (c < 0) return 0;
    if (c > hi) return hi;
    return c;
  endfunction

endpackage

// File: rtl/img_filter_downscaler_ram.sv
// Single-port pixel RAM with registered, enable-gated read data (holds when not reading).
module pixel_ram #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 64,
  parameter int unsigned AddrW = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  localparam int unsigned IdxW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // Storage is intentionally not reset; callers keep addr_i in range when enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i[IdxW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i[IdxW-1:0]];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/img_filter_downscaler.sv
// 3x3 binomial smoothing engine with optional 2:1 decimation; 11 cycles per output pixel.
module img_filter_downscaler
  import img_pkg::*;
#(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        status,
  input  logic              ds_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [PIX_W-1:0]  data,
  output logic              end_process,
  output logic [PIX_W-1:0]  out
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned XW   = $clog2(IMG_W);
  localparam int unsigned YW   = $clog2(IMG_H);
  localparam int unsigned SW   = PIX_W + 4;

  fsm_state_e state_q, state_d;

  logic              ds_q, ds_d;
  logic [XW-1:0]     ox_q, ox_d;
  logic [YW-1:0]     oy_q, oy_d;
  logic [1:0]        tr_q, tr_d, tc_q, tc_d;
  logic [2:0]        w_q, w_d;
  logic [SW-1:0]     acc_q, acc_d;
  logic              end_q, end_d;
  logic              oob_q, oob_d;

  logic              proc;
  int unsigned       ow_c, oh_c;
  logic              last_x, last_y;
  logic              in_rng, out_rng;
  int                cx_c, cy_c, tx_c, ty_c;
  logic [3:0]        tap_k;
  logic [ADDR_W-1:0] tap_addr, wr_addr;
  logic [SW-1:0]     prod_c, sum_rnd;
  logic [PIX_W-1:0]  result;

  logic              in_we, in_re, out_we, out_re;
  logic [ADDR_W-1:0] in_addr, out_addr;
  logic [PIX_W-1:0]  in_rdata, out_rdata;

  assign proc    = (status == ST_PROC);
  assign ow_c    = ds_q ? IMG_W / 2 : IMG_W;
  assign oh_c    = ds_q ? IMG_H / 2 : IMG_H;
  assign last_x  = (32'(ox_q) == ow_c - 1);
  assign last_y  = (32'(oy_q) == oh_c - 1);
  assign in_rng  = (32'(addr) < NPIX);
  assign out_rng = (32'(addr) < ow_c * oh_c);

  // Tap (tr,tc) sits at offset (tc-1, tr-1) from the centre pixel.
  assign cx_c     = ds_q ? 2 * int'(ox_q) : int'(ox_q);
  assign cy_c     = ds_q ? 2 * int'(oy_q) : int'(oy_q);
  assign tx_c     = clamp_coord(cx_c + int'(tc_q) - 1, int'(IMG_W) - 1);
  assign ty_c     = clamp_coord(cy_c + int'(tr_q) - 1, int'(IMG_H) - 1);
  assign tap_addr = ADDR_W'(ty_c * int'(IMG_W) + tx_c);
  assign tap_k    = 4'(int'(tr_q) * 3 + int'(tc_q));
  assign wr_addr  = ADDR_W'(32'(oy_q) * ow_c + 32'(ox_q));

  // RAM data lags the issued tap by one cycle, so it pairs with the registered weight.
  assign prod_c  = SW'(in_rdata) * SW'(w_q);
  assign sum_rnd = acc_q + SW'(ROUND);
  assign result  = PIX_W'(sum_rnd >> SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (proc) state_d = StFetch;
      StFetch: begin
        if (!proc) state_d = StIdle;
        else if (tr_q == 2'd2 && tc_q == 2'd2) state_d = StLast;
      end
      StLast:  state_d = proc ? StWrite : StIdle;
      StWrite: begin
        if (!proc) state_d = StIdle;
        else if (last_x && last_y) state_d = StDone;
        else state_d = StFetch;
      end
      StDone:  if (!proc) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_we    = (status == ST_LOAD) && in_rng;
    in_re    = (state_q == StFetch) && proc;
    in_addr  = in_re ? tap_addr : addr;
    out_we   = (state_q == StWrite) && proc;
    out_re   = (status == ST_READ) && out_rng;
    out_addr = out_we ? wr_addr : addr;
    oob_d    = (status == ST_READ) ? !out_rng : oob_q;
    end_d    = (state_q == StDone) && proc;
  end

  always_comb begin
    ds_d  = ds_q;
    ox_d  = ox_q;
    oy_d  = oy_q;
    tr_d  = tr_q;
    tc_d  = tc_q;
    w_d   = w_q;
    acc_d = acc_q;
    case (state_q)
      StIdle: begin
        if (proc) begin
          ds_d  = ds_en;
          ox_d  = '0;
          oy_d  = '0;
          tr_d  = '0;
          tc_d  = '0;
          acc_d = '0;
        end
      end
      StFetch: begin
        w_d   = KERNEL_W[tap_k];
        acc_d = (tr_q == 2'd0 && tc_q == 2'd0) ? '0 : acc_q + prod_c;
        if (tc_q == 2'd2) begin
          tc_d = '0;
          tr_d = tr_q + 2'd1;
        end else begin
          tc_d = tc_q + 2'd1;
        end
      end
      StLast:  acc_d = acc_q + prod_c;
      StWrite: begin
        tr_d = '0;
        tc_d = '0;
        if (last_x) begin
          ox_d = '0;
          oy_d = oy_q + YW'(1);
        end else begin
          ox_d = ox_q + XW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ds_q  <= 1'b0;
      ox_q  <= '0;
      oy_q  <= '0;
      tr_q  <= '0;
      tc_q  <= '0;
      w_q   <= '0;
      acc_q <= '0;
      end_q <= 1'b0;
      oob_q <= 1'b0;
    end else begin
      ds_q  <= ds_d;
      ox_q  <= ox_d;
      oy_q  <= oy_d;
      tr_q  <= tr_d;
      tc_q  <= tc_d;
      w_q   <= w_d;
      acc_q <= acc_d;
      end_q <= end_d;
      oob_q <= oob_d;
    end
  end

  pixel_ram #(
    .Width(PIX_W),
    .Depth(NPIX),
    .AddrW(ADDR_W)
  ) u_in_ram (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .we_i   (in_we),
    .re_i   (in_re),
    .addr_i (in_addr),
    .wdata_i(data),
    .rdata_o(in_rdata)
  );

  pixel_ram #(
    .Width(PIX_W),
    .Depth(NPIX),
    .AddrW(ADDR_W)
  ) u_out_ram (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .we_i   (out_we),
    .re_i   (out_re),
    .addr_i (out_addr),
    .wdata_i(result),
    .rdata_o(out_rdata)
  );

  assign end_process = end_q;
  assign out         = oob_q ? '0 : out_rdata;

endmodule

// File: tb/tb_img_filter_downscaler.sv
// Directed bench for img_filter_downscaler on an 8x8 frame.
module tb_img_filter_downscaler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] status = 2'b00;
  logic       ds_en = 1'b0;
  logic [7:0] addr = 8'd0;
  logic [7:0] data = 8'd0;
  logic       end_process;
  logic [7:0] out;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] frame [64];
  logic [7:0] expv  [64];

  img_filter_downscaler #(
    .PIX_W (8),
    .IMG_W (8),
    .IMG_H (8),
    .ADDR_W(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .status     (status),
    .ds_en      (ds_en),
    .addr       (addr),
    .data       (data),
    .end_process(end_process),
    .out        (out)
  );

  always #5 clk = ~clk;

  task automatic fill_frame(input logic [7:0] v);
    for (int i = 0; i < 64; i++) frame[i] = v;
  endtask

  task automatic load_frame();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      status = 2'b10;
      addr   = 8'(i);
      data   = frame[i];
    end
    @(negedge clk);
    status = 2'b00;
  endtask

  // Returns clocks from the start edge until end_process is seen high, or -1 on timeout.
  task automatic run_process(input logic ds, output int cycles);
    @(negedge clk);
    status = 2'b01;
    ds_en  = ds;
    @(posedge clk);
    #1 ds_en = ~ds;
    cycles = -1;
    for (int n = 1; n <= 1000; n++) begin
      @(posedge clk);
      #1;
      if (end_process === 1'b1) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic read_px(input int a, output logic [7:0] v);
    @(negedge clk);
    status = 2'b11;
    addr   = 8'(a);
    @(posedge clk);
    #1 v = out;
  endtask

  task automatic test_reset();
    #12;
    n_total++;
    if (end_process !== 1'b0) $display("FAIL reset_end: got %b expected 0", end_process);
    else n_pass++;
    n_total++;
    if (out !== 8'd0) $display("FAIL reset_out: got %0d expected 0", out);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_constant_ds();
    int c;
    logic [7:0] v;
    fill_frame(8'd100);
    load_frame();
    run_process(1'b1, c);
    n_total++;
    if (c != 177) $display("FAIL const_latency: got %0d expected 177", c);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      read_px(i, v);
      n_total++;
      if (v !== 8'd100) $display("FAIL const_px%0d: got %0d expected 100", i, v);
      else n_pass++;
    end
    read_px(16, v);
    n_total++;
    if (v !== 8'd0) $display("FAIL const_oob16: got %0d expected 0", v);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int c;
    run_process(1'b1, c);
    n_total++;
    if (c != 177) $display("FAIL b2b_first: got %0d expected 177", c);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (end_process !== 1'b1) $display("FAIL done_hold: got %b expected 1", end_process);
    else n_pass++;
    @(negedge clk);
    status = 2'b00;
    @(posedge clk);
    #1;
    n_total++;
    if (end_process !== 1'b0) $display("FAIL done_exit: got %b expected 0", end_process);
    else n_pass++;
    run_process(1'b1, c);
    n_total++;
    if (c != 177) $display("FAIL b2b_second: got %0d expected 177", c);
    else n_pass++;
  endtask

  task automatic test_impulse();
    int c;
    logic [7:0] v;
    fill_frame(8'd0);
    frame[36] = 8'd160;
    load_frame();
    for (int i = 0; i < 64; i++) expv[i] = 8'd0;
    expv[36] = 8'd40;
    expv[35] = 8'd20; expv[37] = 8'd20; expv[28] = 8'd20; expv[44] = 8'd20;
    expv[27] = 8'd10; expv[29] = 8'd10; expv[43] = 8'd10; expv[45] = 8'd10;
    run_process(1'b0, c);
    n_total++;
    if (c != 705) $display("FAIL impulse_latency: got %0d expected 705", c);
    else n_pass++;
    for (int i = 0; i < 64; i++) begin
      read_px(i, v);
      n_total++;
      if (v !== expv[i]) $display("FAIL impulse_px%0d: got %0d expected %0d", i, v, expv[i]);
      else n_pass++;
    end
  endtask

  task automatic test_corner();
    int c;
    logic [7:0] v;
    fill_frame(8'd0);
    frame[0] = 8'd255;
    load_frame();
    @(negedge clk);
    status = 2'b10;
    addr   = 8'd64;
    data   = 8'd0;
    @(negedge clk);
    status = 2'b00;
    run_process(1'b1, c);
    n_total++;
    if (c != 177) $display("FAIL corner_latency: got %0d expected 177", c);
    else n_pass++;
    read_px(0, v);
    n_total++;
    if (v !== 8'd143) $display("FAIL corner_px0: got %0d expected 143", v);
    else n_pass++;
    read_px(1, v);
    n_total++;
    if (v !== 8'd0) $display("FAIL corner_px1: got %0d expected 0", v);
    else n_pass++;
    read_px(4, v);
    n_total++;
    if (v !== 8'd0) $display("FAIL corner_px4: got %0d expected 0", v);
    else n_pass++;
  endtask

  task automatic test_abort();
    int c;
    int seen_hi;
    logic [7:0] v;
    fill_frame(8'd50);
    load_frame();
    @(negedge clk);
    status = 2'b01;
    ds_en  = 1'b1;
    @(posedge clk);
    repeat (50) @(posedge clk);
    @(negedge clk);
    status = 2'b10;
    addr   = 8'd200;
    data   = 8'd0;
    seen_hi = 0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk);
      #1 if (end_process !== 1'b0) seen_hi++;
    end
    n_total++;
    if (seen_hi != 0) $display("FAIL abort_end: got %0d high cycles expected 0", seen_hi);
    else n_pass++;
    run_process(1'b1, c);
    n_total++;
    if (c != 177) $display("FAIL abort_rerun: got %0d expected 177", c);
    else n_pass++;
    read_px(0, v);
    n_total++;
    if (v !== 8'd50) $display("FAIL abort_px0: got %0d expected 50", v);
    else n_pass++;
    read_px(15, v);
    n_total++;
    if (v !== 8'd50) $display("FAIL abort_px15: got %0d expected 50", v);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int c;
    logic [7:0] v;
    read_px(0, v);
    n_total++;
    if (v !== 8'd50) $display("FAIL pre_reset_read: got %0d expected 50", v);
    else n_pass++;
    @(negedge clk);
    status = 2'b01;
    ds_en  = 1'b1;
    @(posedge clk);
    repeat (14) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (out !== 8'd0) $display("FAIL arst_out: got %0d expected 0", out);
    else n_pass++;
    n_total++;
    if (end_process !== 1'b0) $display("FAIL arst_end_fetch: got %b expected 0", end_process);
    else n_pass++;
    status = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    run_process(1'b1, c);
    n_total++;
    if (c != 177) $display("FAIL arst_rerun: got %0d expected 177", c);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (end_process !== 1'b0) $display("FAIL arst_end_done: got %b expected 0", end_process);
    else n_pass++;
    status = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    run_process(1'b1, c);
    n_total++;
    if (c != 177) $display("FAIL arst_rerun2: got %0d expected 177", c);
    else n_pass++;
    read_px(15, v);
    n_total++;
    if (v !== 8'd50) $display("FAIL arst_px15: got %0d expected 50", v);
    else n_pass++;
  endtask

  task automatic test_read_bounds();
    logic [7:0] v;
    read_px(16, v);
    n_total++;
    if (v !== 8'd0) $display("FAIL rd_oob16: got %0d expected 0", v);
    else n_pass++;
    @(negedge clk);
    status = 2'b11;
    addr   = 8'd15;
    #1;
    n_total++;
    if (out !== 8'd0) $display("FAIL rd_latency: got %0d expected 0 before edge", out);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (out !== 8'd50) $display("FAIL rd_px15: got %0d expected 50", out);
    else n_pass++;
    @(negedge clk);
    status = 2'b00;
    addr   = 8'd16;
    @(posedge clk);
    #1;
    n_total++;
    if (out !== 8'd50) $display("FAIL idle_hold: got %0d expected 50", out);
    else n_pass++;
    @(negedge clk);
    status = 2'b10;
    addr   = 8'd200;
    data   = 8'd7;
    @(posedge clk);
    #1;
    n_total++;
    if (out !== 8'd50) $display("FAIL load_hold: got %0d expected 50", out);
    else n_pass++;
    @(negedge clk);
    status = 2'b00;
  endtask

  initial begin
    test_reset();
    test_constant_ds();
    test_back_to_back();
    test_impulse();
    test_corner();
    test_abort();
    test_async_reset();
    test_read_bounds();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
